extremum_tracker: RTL and testbench
===================================

# extremum_tracker

Streaming stage directly downstream of the 2-bit magnitude comparator/select mux. It consumes a frame of unsigned operands and, per frame, tracks the running minimum (`select`=0, the A<B path) or maximum (`select`=1, the A>B path). At frame end it reports the extremum value, its position in the frame and the sample count over a valid/ready handshake. The block is registered throughout and replaces the open-loop, per-pair compare with a frame-level result.

## Interface
- `WIDTH`, 2, operand width in bits (unsigned).
- `CNT_W`, 4, width of the sample count and index fields.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `clear`  in  1  synchronous frame abort.
- `select`  in  1  0 = track minimum, 1 = track maximum; sampled only with the first sample of a frame.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept a sample.
- `in_data`  in  WIDTH  operand.
- `in_last`  in  1  marks the final sample of the frame.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_ext`  out  WIDTH  extremum value.
- `out_index`  out  CNT_W  zero-based position of the extremum in the frame.
- `out_count`  out  CNT_W  number of samples in the frame (saturating).
- `out_mode`  out  1  the `select` value latched for this frame.

## Operation
- **States:** EMPTY, TRACK, REPORT.
  - EMPTY: no frame in progress; `in_ready`=1.
  - TRACK: frame in progress; `in_ready`=1.
  - REPORT: result held; `in_ready`=0, `out_valid`=1.
- **Accept:** a sample is accepted when `in_valid & in_ready`.
- **In EMPTY, on accept:**
  - ext <= `in_data`; index <= 0; count <= 1; mode <= `select`.
  - If `in_last`=1, go to REPORT (single-sample frame). Otherwise go to TRACK.
- **In TRACK, on accept:**
  - Replace ext with `in_data` when `in_data` < ext (mode 0) or `in_data` > ext (mode 1). Compare is unsigned and strict.
  - When ext is replaced, index <= count (value before increment).
  - count <= count+1, saturating at 2^CNT_W−1. Once count has saturated, further replacements load index with the saturated value.
  - On `in_last`, go to REPORT.
  - Ties keep the earlier sample: first occurrence wins.
  - `select` is ignored in TRACK.
- **In REPORT:** when `out_valid & out_ready`, go to EMPTY. Input is not accepted in the same cycle; `in_ready` rises the next cycle.
- **`clear`:**
  - Forces EMPTY from any state and drops `out_valid`.
  - Any partial frame or held result is discarded.
  - Takes priority over both handshakes in the same cycle.
- **`rst_n`:** overrides `clear`.
- **Reset values (while `rst_n`=0, and the cycle it is sampled):**
  - state = EMPTY; `in_ready`=0; `out_valid`=0.
  - `out_ext`=0; `out_index`=0; `out_count`=0; `out_mode`=0.
  - `in_ready` goes to 1 on the first edge with `rst_n`=1.
- **Reset mid-frame:** the partial frame is lost and no result is produced.
- **Output stability:** `out_ext`, `out_index`, `out_count` and `out_mode` are registered and hold stable throughout REPORT. They hold their last values in EMPTY, except on reset.

## Timing
- Throughput: one sample per cycle in EMPTY/TRACK.
- Latency: `out_valid` rises the edge after the `in_last` sample is accepted, and result fields are valid in that same cycle.
- `out_valid` stays high until `out_ready`, with no combinational path from `out_ready` to `out_valid`.
- Minimum frame period is N+1 cycles for N samples with `out_ready` tied high: one REPORT cycle per frame.
- `in_ready` is registered (derived from state), not from `out_ready`.
- All inputs are sampled on the rising edge of `clk`.

## Test plan
1. **Reset:** hold `rst_n`=0 for 3 cycles with `in_valid`=1.
   - During reset: `in_ready`=0, `out_valid`=0, all outputs 0, no sample accepted.
   - Release: `in_ready`=1 the next cycle.
2. **Min, mode 0:** frame 2,1,3,1(last), `out_ready`=1.
   - `out_valid` 1 cycle after last; `out_ext`=1, `out_index`=1 (tie keeps first), `out_count`=4, `out_mode`=0.
3. **Max, mode 1:** frame 0,3,3,2(last).
   - `out_ext`=3, `out_index`=1, `out_count`=4.
   - Toggling `select` mid-frame leaves `out_mode`=1.
4. **Backpressure:** single-sample frame 2 (last) with `out_ready`=0 for 5 cycles.
   - `out_valid`=1 and `in_ready`=0 held for all 5 cycles; fields stable.
   - `out_ready`=1 → EMPTY, `in_ready`=1 next cycle.
5. **Saturation:** 20-sample max frame, all 0 except value 3 at position 18.
   - `out_count`=15, `out_index`=15, `out_ext`=3.
6. **Clear:**
   - Assert `clear` after 2 samples: no result appears, and a new frame 1(last) reports `out_count`=1.
   - Assert `clear` together with `out_ready` in REPORT: `out_valid` drops and the state is EMPTY.

Source files
------------

// File: rtl/extremum_tracker.sv
// Frame-level min/max tracker. It reports the extremum, its position in the frame and
// the sample count over a valid/ready handshake, with all outputs registered.
module extremum_tracker #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             select,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_ext,
  output logic [CNT_W-1:0] out_index,
  output logic [CNT_W-1:0] out_count,
  output logic             out_mode
);
  typedef enum logic [1:0] {EMPTY, TRACK, REPORT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] ext;
  logic [CNT_W-1:0] idx, cnt;
  logic             mode;

  logic             accept, better;
  logic [WIDTH-1:0] f_ext;
  logic [CNT_W-1:0] f_idx, f_cnt;
  logic             f_mode;

  assign accept = in_valid & in_ready;
  assign better = mode ? (in_data > ext) : (in_data < ext);

  // Running values after folding in the current sample. The first sample of a frame seeds them.
  always_comb begin
    f_ext  = ext;
    f_idx  = idx;
    f_cnt  = cnt;
    f_mode = mode;
    if (state == EMPTY) begin
      f_ext  = in_data;
      f_idx  = '0;
      f_cnt  = CNT_W'(1);
      f_mode = select;
    end else begin
      if (better) begin
        f_ext = in_data;
        f_idx = cnt;
      end
      f_cnt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      ext       <= '0;
      idx       <= '0;
      cnt       <= '0;
      mode      <= 1'b0;
      out_ext   <= '0;
      out_index <= '0;
      out_count <= '0;
      out_mode  <= 1'b0;
    end else if (clear) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY, TRACK: begin
          in_ready <= 1'b1;
          if (accept) begin
            ext  <= f_ext;
            idx  <= f_idx;
            cnt  <= f_cnt;
            mode <= f_mode;
            if (in_last) begin
              state     <= REPORT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_ext   <= f_ext;
              out_index <= f_idx;
              out_count <= f_cnt;
              out_mode  <= f_mode;
            end else begin
              state <= TRACK;
            end
          end
        end
        REPORT: begin
          if (out_ready) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_extremum_tracker.sv
// Bench for extremum_tracker: directed vector table, corner-case sequences and
// random frames checked against a frame-level reference model.
module tb_extremum_tracker;
  logic       clk = 1'b0;
  logic       rst_n, clear, sel, in_valid, in_ready, in_last, out_valid, out_ready, out_mode;
  logic [1:0] in_data, out_ext;
  logic [3:0] out_index, out_count;

  int n_pass = 0;
  int n_total = 0;

  extremum_tracker #(.WIDTH(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .select(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_ext(out_ext),
    .out_index(out_index), .out_count(out_count), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         len;
    int         s [4];
    logic       mode;
    logic       tog;
    int         hold;
    logic [1:0] ext;
    logic [3:0] idx;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: first occurrence of the strict min/max; index and count clip at 15.
  task automatic model(input int q[$], input logic mode, output int e, output int ix, output int c);
    e  = q[0];
    ix = 0;
    for (int i = 1; i < q.size(); i++)
      if (mode ? (q[i] > e) : (q[i] < e)) begin
        e  = q[i];
        ix = (i > 15) ? 15 : i;
      end
    c = (q.size() > 15) ? 15 : q.size();
  endtask

  task automatic run_frame(input int q[$], input logic mode, input logic tog, input int hold,
                           input int e_ext, input int e_idx, input int e_cnt);
    int w = 0;
    while (!in_ready && w < 10) begin step(); w++; end
    chk("ready_before_frame", in_ready, 1);
    out_ready = (hold == 0);
    for (int i = 0; i < q.size(); i++) begin
      in_valid = 1'b1;
      in_data  = q[i][1:0];
      in_last  = (i == q.size() - 1);
      sel      = (i == 0) ? mode : (tog ? ~mode : mode);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    sel      = ~mode;
    chk("out_valid_latency", out_valid, 1);
    chk("in_ready_report", in_ready, 0);
    chk("out_ext", out_ext, e_ext);
    chk("out_index", out_index, e_idx);
    chk("out_count", out_count, e_cnt);
    chk("out_mode", out_mode, mode);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("held_valid", out_valid, 1);
      chk("held_in_ready", in_ready, 0);
      chk("held_ext", out_ext, e_ext);
      chk("held_count", out_count, e_cnt);
    end
    out_ready = 1'b1;
    step();
    chk("post_report_valid", out_valid, 0);
    chk("post_report_ready", in_ready, 1);
  endtask

  initial begin
    int q[$];
    int e, ix, c;
    rst_n = 1'b0; clear = 1'b0; sel = 1'b0; in_valid = 1'b1; in_data = 2'd3;
    in_last = 1'b1; out_ready = 1'b1;

    tbl[0] = '{len:4, s:'{2,1,3,1}, mode:1'b0, tog:1'b0, hold:0, ext:2'd1, idx:4'd1, cnt:4'd4};
    tbl[1] = '{len:4, s:'{0,3,3,2}, mode:1'b1, tog:1'b1, hold:0, ext:2'd3, idx:4'd1, cnt:4'd4};
    tbl[2] = '{len:1, s:'{2,0,0,0}, mode:1'b0, tog:1'b0, hold:5, ext:2'd2, idx:4'd0, cnt:4'd1};
    tbl[3] = '{len:3, s:'{3,3,3,0}, mode:1'b0, tog:1'b1, hold:1, ext:2'd3, idx:4'd0, cnt:4'd3};
    tbl[4] = '{len:4, s:'{1,2,0,0}, mode:1'b0, tog:1'b1, hold:0, ext:2'd0, idx:4'd2, cnt:4'd4};
    tbl[5] = '{len:4, s:'{2,0,1,3}, mode:1'b1, tog:1'b0, hold:2, ext:2'd3, idx:4'd3, cnt:4'd4};

    // Reset held with a valid last sample on the input.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_fields", {out_ext, out_index, out_count, out_mode}, 0);
    end
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    in_valid = 1'b0; in_last = 1'b0;
    step();
    chk("rel_no_accept", out_valid, 0);

    foreach (tbl[k]) begin
      q.delete();
      for (int i = 0; i < tbl[k].len; i++) q.push_back(tbl[k].s[i]);
      run_frame(q, tbl[k].mode, tbl[k].tog, tbl[k].hold, tbl[k].ext, tbl[k].idx, tbl[k].cnt);
    end

    // Saturation: 20-sample max frame with the peak at position 18.
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(i == 18 ? 3 : 0);
    run_frame(q, 1'b1, 1'b0, 0, 3, 15, 15);

    // Clear after two samples; clear also wins over an in-flight last sample.
    in_valid = 1'b1; in_data = 2'd0; in_last = 1'b0; sel = 1'b0;
    step(); step();
    clear = 1'b1; in_data = 2'd0; in_last = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("clear_no_result", out_valid, 0);
    chk("clear_in_ready", in_ready, 1);
    step();
    chk("clear_no_result2", out_valid, 0);
    q.delete(); q.push_back(1);
    run_frame(q, 1'b0, 1'b0, 0, 1, 0, 1);

    // Clear together with out_ready while a result is held.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 2'd2; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("rep_valid", out_valid, 1);
    clear = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_rep_valid", out_valid, 0);
    chk("clear_rep_ready", in_ready, 1);
    step();
    chk("clear_rep_stay", out_valid, 0);

    // Random frames against the reference model.
    for (int f = 0; f < 40; f++) begin
      logic m;
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) q.push_back(int'($urandom_range(0, 3)));
      m = 1'($urandom_range(0, 1));
      model(q, m, e, ix, c);
      run_frame(q, m, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), e, ix, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=%0d expected=%0d", n_total, 0);
    $fatal(1);
  end
endmodule
